// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first a-b using one full-subtractor cell and a registered borrow
// Define SERIAL_SUB_OVF_EN to enable the signed overflow flag; otherwise overflow is tied to 0.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] sa, sb, res, res_n;
  logic br, br_n, d, last;
  always_comb begin
    d = sa[0] ^ sb[0] ^ br;
    br_n = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    res_n = {d, res[WIDTH-1:1]};
    last = cnt == CW'(WIDTH - 1);
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = (state == IDLE && start) ? SHIFT :
              (state == SHIFT && last) ? DONE :
              (state == DONE) ? IDLE : state;
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
  end
  always_ff @(posedge clk)
    if (reset) begin
      sa <= '0;
      sb <= '0;
      res <= '0;
      br <= 1'b0;
      cnt <= '0;
      diff <= '0;
      borrow_out <= 1'b0;
    end else if (state == IDLE && start) begin
      sa <= op_a;
      sb <= op_b;
      res <= '0;
      br <= 1'b0;
      cnt <= '0;
    end else if (state == SHIFT) begin
      sa <= sa >> 1;
      sb <= sb >> 1;
      res <= res_n;
      br <= br_n;
      cnt <= cnt + 1'b1;
      if (last) begin
        diff <= res_n;
        borrow_out <= br_n;
      end
    end
`ifdef SERIAL_SUB_OVF_EN
  logic a_msb, b_msb;
  // on the last shift d is the result MSB
  always_ff @(posedge clk)
    if (reset) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      overflow <= 1'b0;
    end else if (state == IDLE && start) begin
      a_msb <= op_a[WIDTH-1];
      b_msb <= op_b[WIDTH-1];
    end else if (state == SHIFT && last) begin
      overflow <= (a_msb != b_msb) && (d != a_msb);
    end
`else
  assign overflow = 1'b0;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vector table plus multi-cycle corner sequences and a random stream
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic reset, start, busy, done, borrow_out, overflow;
  logic [7:0] op_a, op_b, diff;
  int pass_cnt = 0, total_cnt = 0;
  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out), .overflow(overflow)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] a, b, d;
    logic bo, ov;
  } vec_t;
  vec_t vecs[8];
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", n, got, exp);
    else pass_cnt++;
  endtask
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int lat);
    @(negedge clk);
    op_a = a;
    op_b = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op_a = ~a;
    op_b = ~b;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask
  initial begin
    int lat, w, t, prev, nd;
    logic [7:0] ea, eb, ed;
    vecs[0] = '{8'h5A, 8'h23, 8'h37, 1'b0, 1'b0};
    vecs[1] = '{8'h10, 8'h20, 8'hF0, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vecs[6] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vecs[7] = '{8'h09, 8'h04, 8'h05, 1'b0, 1'b0};
    reset = 1'b1;
    start = 1'b0;
    op_a = '0;
    op_b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow_out, 0);
    chk("rst_ovf", overflow, 0);
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d_latency", i), lat, 9);
      chk($sformatf("v%0d_busy", i), busy, 1);
      chk($sformatf("v%0d_diff", i), diff, vecs[i].d);
      chk($sformatf("v%0d_borrow", i), borrow_out, vecs[i].bo);
`ifdef SERIAL_SUB_OVF_EN
      chk($sformatf("v%0d_ovf", i), overflow, vecs[i].ov);
`else
      chk($sformatf("v%0d_ovf", i), overflow, 0);
`endif
    end
    // start pulses during SHIFT and DONE must be ignored
    @(negedge clk);
    op_a = 8'h40;
    op_b = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 3) begin
        start = 1'b1;
        op_a = 8'h00;
        op_b = 8'hFF;
      end
      if (lat == 4) start = 1'b0;
    end
    chk("ign_latency", lat, 9);
    chk("ign_diff", diff, 8'h3F);
    start = 1'b1;
    @(negedge clk);
    chk("ign_single_done", done, 0);
    chk("ign_idle", busy, 0);
    chk("ign_diff_held", diff, 8'h3F);
    @(negedge clk);
    start = 1'b0;
    chk("after_done_accept", busy, 1);
    w = 0;
    while (!done && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("after_done_diff", diff, 8'h01);
    chk("after_done_borrow", borrow_out, 1);
    // reset in the middle of an operation
    @(negedge clk);
    op_a = 8'h33;
    op_b = 8'h11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_borrow", borrow_out, 0);
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);
    run_op(8'h09, 8'h04, lat);
    chk("abort_next_latency", lat, 9);
    chk("abort_next_diff", diff, 8'h05);
    // continuous start: random stream, fixed spacing between completions
    @(negedge clk);
    ea = 8'($urandom_range(0, 255));
    eb = 8'($urandom_range(0, 255));
    op_a = ea;
    op_b = eb;
    start = 1'b1;
    t = 0;
    prev = 0;
    for (int k = 0; k < 1000; k++) begin
      w = 0;
      do begin
        @(negedge clk);
        t++;
        w++;
      end while (!done && w < 40);
      ed = ea - eb;
      chk("rand_diff", diff, ed);
      chk("rand_borrow", borrow_out, ea < eb);
      if (k > 0) chk("rand_gap", t - prev, 10);
      prev = t;
      ea = 8'($urandom_range(0, 255));
      eb = 8'($urandom_range(0, 255));
      op_a = ea;
      op_b = eb;
    end
    start = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
